con4_win_scan: RTL and testbench
================================

# con4_win_scan

Sequential win/draw detector for the Connect 4 datapath. The move controller writes the 6x7 board of 2-bit cells (00 empty, 01 player 1, 10 player 2). This block is its reader: on request it walks the board through a one-cell-per-cycle read port and reports whether the requested player has four in a row. It also optionally reports a full-board draw. It feeds the controller's CHECK_1_WIN / CHECK_2_WIN / CHECK_DRAW states.

## Interface
- No parameters; board fixed at 6 rows (0 bottom to 5 top) x 7 columns (0 to 6).
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  request a scan; sampled only in IDLE.
- player  in  2  cell code to search for; latched on accepted start.
- rd_row  out  3  board read row address, registered.
- rd_col  out  3  board read column address, registered.
- rd_data  in  2  board cell at (rd_row, rd_col).
  - Combinational from the board.
  - Sampled at the end of the same cycle.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse; results are valid from this cycle.
- win  out  1  four-in-a-row found for the latched player.
- draw  out  1  top row completely filled and no win.
- win_row  out  3  anchor row of the winning window.
- win_col  out  3  anchor column of the winning window.
- win_dir  out  2  window direction:
  - 0 = +col
  - 1 = +row
  - 2 = +row+col
  - 3 = +row-col

## Operation
- States: IDLE, SCAN, DRAWCHK (macro only), DONE.
- Reset (async, any state):
  - State goes to IDLE.
  - All outputs go to 0, including rd_row, rd_col, win_row, win_col and win_dir.
- IDLE:
  - On start=1: latch player, clear win/draw/win_*, enter SCAN with slot (r=0,c=0,d=0), k=0.
  - start while busy or in DONE is ignored.
- Invalid player (00 or 11) skips the scan: SCAN is bypassed, DONE follows directly, win=0 and draw=0.
- Slot order: r 0..5 outer, c 0..6, d 0..3 inner; 168 slots total.
- A slot is valid when all four cells (r+k*dr, c+k*dc), k=0..3, lie on the board. There are 69 valid slots.
- Invalid slot:
  - Consumes exactly one cycle; no compare is made.
  - rd_row/rd_col point at the anchor.
- Valid slot:
  - One cell is read per cycle, k=0..3, with rd_row/rd_col = anchor + k*direction.
  - On mismatch (rd_data != player): abort the slot and advance to the next slot in the following cycle.
  - On match with k=3: set win=1, capture win_row/win_col/win_dir, go to DONE.
- The first winning window in slot order is reported; the scan stops immediately.
- Slot 167 finished without a win: go to DRAWCHK if the macro is enabled, else to DONE.
- DRAWCHK:
  - Reads row 5, columns 0..6, one per cycle.
  - An empty cell ends the check with draw=0.
  - Seven non-empty cells give draw=1.
  - Then go to DONE.
- DONE:
  - done=1 for one cycle, busy=0, then IDLE.
- Results hold until the next accepted start or reset.
- Column arithmetic for d=3 must not wrap. c-k<0 makes the slot invalid; no 3-bit underflow is allowed.

## Timing
- Start sampled at edge E0. SCAN's first read cycle is E0..E1. busy is high from E0+.
- Read latency: zero cycles (same-cycle combinational data), one cell per cycle.
- Empty board, valid player:
  - 168 SCAN cycles.
  - With macro, 1 DRAWCHK cycle.
  - done is high in cycle 170 (macro on) or 169 (macro off) after E0.
- Worst-case bound: 168 + 69*3 + 7 + 1 = 383 cycles.
- Invalid player: done is high in the cycle after E0.
- rd_row/rd_col hold their last value in IDLE/DONE.

## Configuration
- CON4_DRAW_CHECK_EN defined:
  - The DRAWCHK state and draw logic are present.
  - draw is computed as above.
- Not defined:
  - No DRAWCHK state; SCAN goes straight to DONE.
  - draw is tied to 0.

## Test plan
- Empty board, player=01, start pulse:
  - Macro on: done at cycle 170 with win=0, draw=0.
  - Macro off: done at cycle 169.
- P1 at row 0, cols 0..3, player=01: done at cycle 5, win=1, win_row=0, win_col=0, win_dir=0.
- P2 at col 6, rows 2..5, player=10: win=1, win_row=2, win_col=6, win_dir=1. Repeat with player=01: win=0.
- P1 at (0,3),(1,2),(2,1),(3,0): win=1, win_row=0, win_col=3, win_dir=3. No false hit from column underflow at c<3.
- Full board with no four-in-a-row for either player, macro on, player=01: win=0, draw=1. Same with one top cell emptied: draw=0.
- Start asserted again mid-scan: ignored, result unchanged. Reset asserted mid-scan: busy, done and win go to 0 asynchronously. A new start then completes normally. player=11: done in cycle 1, win=0.

Source files
------------

// File: rtl/con4_win_scan.sv
// Connect 4 win/draw scanner: walks the 6x7 board one cell per cycle looking for four in a row.
// Optional full-top-row draw check is built when CON4_DRAW_CHECK_EN is defined.
module con4_win_scan (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       start_i,
    input  logic [1:0] player_i,
    output logic [2:0] rd_row_o,
    output logic [2:0] rd_col_o,
    input  logic [1:0] rd_data_i,
    output logic       busy_o,
    output logic       done_o,
    output logic       win_o,
    output logic       draw_o,
    output logic [2:0] win_row_o,
    output logic [2:0] win_col_o,
    output logic [1:0] win_dir_o
);

`ifdef CON4_DRAW_CHECK_EN
    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE, S_DRAWCHK} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;
`endif

    state_t     state_q, state_d;
    logic [2:0] r_q, r_d, c_q, c_d;
    logic [1:0] d_q, d_d, k_q, k_d;
    logic [1:0] player_q, player_d;
    logic [2:0] rd_row_q, rd_row_d, rd_col_q, rd_col_d;
    logic       win_q, win_d;
    logic [2:0] win_row_q, win_row_d, win_col_q, win_col_d;
    logic [1:0] win_dir_q, win_dir_d;
`ifdef CON4_DRAW_CHECK_EN
    logic       draw_q, draw_d;
`endif

    logic       slot_ok;
    logic       last_slot;
    logic [2:0] nr, nc;
    logic [1:0] nd;
    logic [2:0] step_col;

    // Direction d=3 walks toward column 0, so its anchor must sit at column 3 or above.
    always_comb begin
        case (d_q)
            2'd0:    slot_ok = (c_q <= 3'd3);
            2'd1:    slot_ok = (r_q <= 3'd2);
            2'd2:    slot_ok = (r_q <= 3'd2) && (c_q <= 3'd3);
            default: slot_ok = (r_q <= 3'd2) && (c_q >= 3'd3);
        endcase
    end

    always_comb begin
        nr = r_q;
        nc = c_q;
        nd = d_q + 2'd1;
        if (d_q == 2'd3) begin
            nd = 2'd0;
            if (c_q == 3'd6) begin
                nc = 3'd0;
                nr = r_q + 3'd1;
            end else begin
                nc = c_q + 3'd1;
            end
        end
    end

    always_comb begin
        case (d_q)
            2'd0, 2'd2: step_col = rd_col_q + 3'd1;
            2'd1:       step_col = rd_col_q;
            default:    step_col = rd_col_q - 3'd1;
        endcase
    end

    assign last_slot = (r_q == 3'd5) && (c_q == 3'd6) && (d_q == 2'd3);

    always_comb begin
        state_d   = state_q;
        r_d       = r_q;
        c_d       = c_q;
        d_d       = d_q;
        k_d       = k_q;
        player_d  = player_q;
        rd_row_d  = rd_row_q;
        rd_col_d  = rd_col_q;
        win_d     = win_q;
        win_row_d = win_row_q;
        win_col_d = win_col_q;
        win_dir_d = win_dir_q;
`ifdef CON4_DRAW_CHECK_EN
        draw_d    = draw_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    player_d  = player_i;
                    win_d     = 1'b0;
                    win_row_d = 3'd0;
                    win_col_d = 3'd0;
                    win_dir_d = 2'd0;
`ifdef CON4_DRAW_CHECK_EN
                    draw_d    = 1'b0;
`endif
                    if (player_i == 2'b01 || player_i == 2'b10) begin
                        state_d  = S_SCAN;
                        r_d      = 3'd0;
                        c_d      = 3'd0;
                        d_d      = 2'd0;
                        k_d      = 2'd0;
                        rd_row_d = 3'd0;
                        rd_col_d = 3'd0;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_SCAN: begin
                if (slot_ok && rd_data_i == player_q) begin
                    if (k_q == 2'd3) begin
                        win_d     = 1'b1;
                        win_row_d = r_q;
                        win_col_d = c_q;
                        win_dir_d = d_q;
                        state_d   = S_DONE;
                    end else begin
                        k_d      = k_q + 2'd1;
                        rd_row_d = rd_row_q + {2'b00, (d_q != 2'd0)};
                        rd_col_d = step_col;
                    end
                end else if (last_slot) begin
`ifdef CON4_DRAW_CHECK_EN
                    state_d  = S_DRAWCHK;
                    rd_row_d = 3'd5;
                    rd_col_d = 3'd0;
`else
                    state_d  = S_DONE;
`endif
                end else begin
                    r_d      = nr;
                    c_d      = nc;
                    d_d      = nd;
                    k_d      = 2'd0;
                    rd_row_d = nr;
                    rd_col_d = nc;
                end
            end
`ifdef CON4_DRAW_CHECK_EN
            S_DRAWCHK: begin
                if (rd_data_i == 2'b00) begin
                    state_d = S_DONE;
                end else if (rd_col_q == 3'd6) begin
                    draw_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    rd_col_d = rd_col_q + 3'd1;
                end
            end
`endif
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= S_IDLE;
            r_q       <= 3'd0;
            c_q       <= 3'd0;
            d_q       <= 2'd0;
            k_q       <= 2'd0;
            player_q  <= 2'd0;
            rd_row_q  <= 3'd0;
            rd_col_q  <= 3'd0;
            win_q     <= 1'b0;
            win_row_q <= 3'd0;
            win_col_q <= 3'd0;
            win_dir_q <= 2'd0;
`ifdef CON4_DRAW_CHECK_EN
            draw_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            r_q       <= r_d;
            c_q       <= c_d;
            d_q       <= d_d;
            k_q       <= k_d;
            player_q  <= player_d;
            rd_row_q  <= rd_row_d;
            rd_col_q  <= rd_col_d;
            win_q     <= win_d;
            win_row_q <= win_row_d;
            win_col_q <= win_col_d;
            win_dir_q <= win_dir_d;
`ifdef CON4_DRAW_CHECK_EN
            draw_q    <= draw_d;
`endif
        end
    end

`ifdef CON4_DRAW_CHECK_EN
    assign busy_o = (state_q == S_SCAN) || (state_q == S_DRAWCHK);
    assign draw_o = draw_q;
`else
    assign busy_o = (state_q == S_SCAN);
    assign draw_o = 1'b0;
`endif
    assign done_o    = (state_q == S_DONE);
    assign rd_row_o  = rd_row_q;
    assign rd_col_o  = rd_col_q;
    assign win_o     = win_q;
    assign win_row_o = win_row_q;
    assign win_col_o = win_col_q;
    assign win_dir_o = win_dir_q;

endmodule

// File: tb/tb_con4_win_scan.sv
// Directed bench for con4_win_scan: a board model answers the read port; vectors hold hand-computed results.
module tb_con4_win_scan;

`ifdef CON4_DRAW_CHECK_EN
    localparam int EMPTY_CYC = 170;
    localparam bit DRAW_EN   = 1'b1;
`else
    localparam int EMPTY_CYC = 169;
    localparam bit DRAW_EN   = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [1:0] player;
    logic [2:0] rd_row, rd_col;
    logic [1:0] rd_data;
    logic       busy, done, win, draw;
    logic [2:0] win_row, win_col;
    logic [1:0] win_dir;

    logic [1:0] board [0:5][0:6];
    logic [1:0] oob_val;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    // Off-board reads return the searched code so any address wrap shows up as a false win.
    assign rd_data = (rd_row < 3'd6 && rd_col < 3'd7) ? board[rd_row][rd_col] : oob_val;

    con4_win_scan dut (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .start_i   (start),
        .player_i  (player),
        .rd_row_o  (rd_row),
        .rd_col_o  (rd_col),
        .rd_data_i (rd_data),
        .busy_o    (busy),
        .done_o    (done),
        .win_o     (win),
        .draw_o    (draw),
        .win_row_o (win_row),
        .win_col_o (win_col),
        .win_dir_o (win_dir)
    );

    typedef struct {
        string      name;
        int         board_id;
        logic [1:0] ply;
        int         cycles;   // 0 = latency not checked
        int         exp_win;
        int         exp_draw;
        int         exp_row;
        int         exp_col;
        int         exp_dir;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic setup_board(input int id);
        for (int r = 0; r < 6; r++)
            for (int c = 0; c < 7; c++)
                board[r][c] = 2'b00;
        case (id)
            1: for (int c = 0; c < 4; c++) board[0][c] = 2'b01;
            2: for (int r = 2; r < 6; r++) board[r][6] = 2'b10;
            3: for (int k = 0; k < 4; k++) board[k][3-k] = 2'b01;
            4: for (int k = 0; k < 3; k++) board[k][2-k] = 2'b01;
            5, 6: begin
                for (int r = 0; r < 6; r++)
                    for (int c = 0; c < 7; c++)
                        board[r][c] = (((r / 2) + c) % 2 == 0) ? 2'b01 : 2'b10;
                if (id == 6) board[5][3] = 2'b00;
            end
            default: ;
        endcase
    endtask

    task automatic wait_done(input string name, output int cyc, output bit got);
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < 500) begin
            @(negedge clk);
            cyc++;
            if (done) got = 1'b1;
        end
        check({name, "_done_seen"}, int'(got), 1);
    endtask

    task automatic run_vec(input vec_t v);
        int cyc;
        bit got;
        setup_board(v.board_id);
        oob_val = v.ply;
        @(negedge clk);
        player = v.ply;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        player = 2'b00;
        @(negedge clk);
        cyc = 1;
        got = done;
        check({v.name, "_busy_c1"}, int'(busy), int'(v.ply == 2'b01 || v.ply == 2'b10));
        while (!got && cyc < 500) begin
            @(negedge clk);
            cyc++;
            if (done) got = 1'b1;
        end
        check({v.name, "_done_seen"}, int'(got), 1);
        if (v.cycles != 0) check({v.name, "_latency"}, cyc, v.cycles);
        check({v.name, "_win"},     int'(win),     v.exp_win);
        check({v.name, "_draw"},    int'(draw),    v.exp_draw);
        check({v.name, "_win_row"}, int'(win_row), v.exp_row);
        check({v.name, "_win_col"}, int'(win_col), v.exp_col);
        check({v.name, "_win_dir"}, int'(win_dir), v.exp_dir);
        @(negedge clk);
        check({v.name, "_done_pulse"}, int'(done), 0);
        check({v.name, "_hold_win"},   int'(win),  v.exp_win);
    endtask

    initial begin
        int cyc;
        bit got;
        rst_n   = 1'b0;
        start   = 1'b0;
        player  = 2'b00;
        oob_val = 2'b00;
        setup_board(0);

        vecs[0] = '{"empty_p1",   0, 2'b01, EMPTY_CYC, 0, 0, 0, 0, 0};
        vecs[1] = '{"row0_p1",    1, 2'b01, 5,         1, 0, 0, 0, 0};
        vecs[2] = '{"bad_p11",    0, 2'b11, 1,         0, 0, 0, 0, 0};
        vecs[3] = '{"col6_p2",    2, 2'b10, 86,        1, 0, 2, 6, 1};
        vecs[4] = '{"col6_p1",    2, 2'b01, EMPTY_CYC, 0, 0, 0, 0, 0};
        vecs[5] = '{"antidiag",   3, 2'b01, 23,        1, 0, 0, 3, 3};
        vecs[6] = '{"underflow",  4, 2'b01, 0,         0, 0, 0, 0, 0};
        vecs[7] = '{"full",       5, 2'b01, 0,         0, int'(DRAW_EN), 0, 0, 0};
        vecs[8] = '{"full_hole",  6, 2'b01, 0,         0, 0, 0, 0, 0};
        vecs[9] = '{"bad_p00",    0, 2'b00, 1,         0, 0, 0, 0, 0};

        #2;
        check("rst_busy",    int'(busy),    0);
        check("rst_done",    int'(done),    0);
        check("rst_win",     int'(win),     0);
        check("rst_draw",    int'(draw),    0);
        check("rst_rd_row",  int'(rd_row),  0);
        check("rst_rd_col",  int'(rd_col),  0);
        check("rst_win_row", int'(win_row), 0);
        check("rst_win_dir", int'(win_dir), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) run_vec(vecs[i]);

        // start with another player mid-scan must not disturb the running scan
        setup_board(3);
        oob_val = 2'b01;
        @(negedge clk);
        player = 2'b01;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        repeat (5) @(negedge clk);
        player = 2'b10;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        player = 2'b00;
        wait_done("restart", cyc, got);
        check("restart_latency", cyc + 6, 23);
        check("restart_win",     int'(win),     1);
        check("restart_win_col", int'(win_col), 3);
        check("restart_win_dir", int'(win_dir), 3);
        repeat (3) @(negedge clk);
        check("restart_hold_win", int'(win),     1);
        check("restart_hold_col", int'(win_col), 3);

        // asynchronous reset in the middle of a scan
        setup_board(0);
        oob_val = 2'b01;
        @(negedge clk);
        player = 2'b01;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (40) @(negedge clk);
        check("midscan_busy", int'(busy), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_busy",   int'(busy),   0);
        check("arst_done",   int'(done),   0);
        check("arst_win",    int'(win),    0);
        check("arst_rd_row", int'(rd_row), 0);
        check("arst_win_col", int'(win_col), 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_vec(vecs[1]);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
